// File: rtl/uart_pkg.sv
// Shared definitions for the board serial-link transmitter.
// Holds the FSM state type and the frame data width.
// No logic; imported by uart_tx and its FIFO.
package uart_pkg;

    // Data bits per 8N1 frame (start and stop bits are implicit).
    localparam int UART_DATA_BITS = 8;

    // Transmit FSM states; encodings 5..7 are illegal and recover to S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read data.
// Latency: a push is visible on count/dout/empty the cycle after it is written.
// Backpressure: push ignored while full, pop ignored while empty; the caller gates both.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     Clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Status is decoded only from the registered count, never from this cycle's push/pop.
    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    // A push while full is dropped even when a pop frees a slot in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy next-state; pointers are log2(DEPTH) wide and wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset empties the FIFO without touching the storage array.
    always_ff @(posedge Clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until a slot is counted as occupied.
    always_ff @(posedge Clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter draining a FIFO_DEPTH byte buffer onto Tx_Serial, LSB first.
// Latency: pop in cycle t -> start bit at t+1, Tx_Done at t+10*CLKS_PER_BIT+1, next pop >= t+10*CLKS_PER_BIT+2.
// Backpressure: Tx_Ready low when buffer full; a strobe while not ready is dropped and flagged on Tx_Overflow.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          Clock,
    input  logic                          reset,
    input  logic                          Tx_DV,
    input  logic [7:0]                    Tx_Byte,
    output logic                          Tx_Ready,
    output logic                          Tx_Overflow,
    output logic                          Tx_Serial,
    output logic                          Tx_Active,
    output logic                          Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(UART_DATA_BITS - 1);

    uart_state_t                 state_q, state_d;
    logic [TW-1:0]               timer_q, timer_d;
    logic [BW-1:0]               bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        serial_q, serial_d;
    logic                        active_q, active_d;
    logic                        done_q, done_d;
    logic                        ovf_q;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic [UART_DATA_BITS-1:0]   fifo_dout;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        timer_last;

    // Byte buffer between the producer and the serial line.
    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .Clock (Clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (Tx_Byte),
        .dout  (fifo_dout),
        .count (Fifo_Count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Tx_Ready is the only combinational output, and it depends only on the registered count.
    assign Tx_Ready    = !fifo_full;
    assign fifo_push   = Tx_DV && Tx_Ready;
    // The FSM only ever pops from IDLE, so a byte pushed this cycle cannot be popped until next cycle.
    assign fifo_pop    = (state_q == S_IDLE) && !fifo_empty;
    assign timer_last  = (timer_q == TIMER_LAST);

    assign Tx_Serial   = serial_q;
    assign Tx_Active   = active_q;
    assign Tx_Done     = done_q;
    assign Tx_Overflow = ovf_q;

    // Frame sequencing: the line value is computed one cycle ahead so Tx_Serial is a flop.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        active_d  = active_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                serial_d  = 1'b1;
                active_d  = 1'b0;
                timer_d   = '0;
                bit_idx_d = '0;
                if (fifo_pop) begin
                    shift_d  = fifo_dout;
                    state_d  = S_START;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                end
            end
            S_START: begin
                if (timer_last) begin
                    timer_d  = '0;
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                end else begin
                    timer_d  = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (timer_last) begin
                    timer_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d  = S_STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                        serial_d  = shift_q[bit_idx_d];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STOP: begin
                serial_d = 1'b1;
                if (timer_last) begin
                    timer_d  = '0;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_CLEANUP;
                end else begin
                    timer_d  = timer_q + TW'(1);
                end
            end
            S_CLEANUP: begin
                // One extra idle-high cycle separates back-to-back frames.
                serial_d = 1'b1;
                active_d = 1'b0;
                timer_d  = '0;
                state_d  = S_IDLE;
            end
            default: begin
                // Corrupted state: park the line high and resynchronise from IDLE.
                state_d   = S_IDLE;
                serial_d  = 1'b1;
                active_d  = 1'b0;
                timer_d   = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // FSM and datapath registers; reset abandons any frame and returns the line high next cycle.
    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    // Overflow flag: one-cycle pulse following each strobe that arrived while the buffer was full.
    always_ff @(posedge Clock) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= Tx_DV && !Tx_Ready;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with C=8, D=4 and a behavioural loopback receiver.
module tb_uart_tx;

    localparam int C     = 8;
    localparam int D     = 4;
    localparam int FRAME = 10 * C;

    logic       Clock = 1'b0;
    logic       reset = 1'b1;
    logic       Tx_DV = 1'b0;
    logic [7:0] Tx_Byte = 8'h00;
    logic       Tx_Ready;
    logic       Tx_Overflow;
    logic       Tx_Serial;
    logic       Tx_Active;
    logic       Tx_Done;
    logic [2:0] Fifo_Count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: buffer contents as a queue plus the timeline of the frame in flight.
    logic [7:0] mq[$];
    logic [7:0] exp_rx[$];
    int         s = 0;
    int         cur_t = -1000;
    logic [7:0] cur_b = 8'h00;
    int         next_pop_ok = 0;
    logic       ovf_exp = 1'b0;
    int         done_cycles[$];
    int         ovf_cycles[$];
    int         drop_cycles[$];
    int         low_cnt = 0;

    // Loopback receiver state.
    logic [7:0] rx_q[$];
    int         rx_frames = 0;
    int         rx_bad = 0;
    logic       rx_prev = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_ok;

    int base;
    int guard;
    int rxn;

    uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .Clock       (Clock),
        .reset       (reset),
        .Tx_DV       (Tx_DV),
        .Tx_Byte     (Tx_Byte),
        .Tx_Ready    (Tx_Ready),
        .Tx_Overflow (Tx_Overflow),
        .Tx_Serial   (Tx_Serial),
        .Tx_Active   (Tx_Active),
        .Tx_Done     (Tx_Done),
        .Fifo_Count  (Fifo_Count)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    // Mid-bit sampling receiver, as a uart_rx at the same CLKS_PER_BIT would do.
    always begin
        @(negedge Clock);
        if (rx_prev === 1'b1 && Tx_Serial === 1'b0) begin
            repeat (C / 2) @(negedge Clock);
            rx_ok = (Tx_Serial === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (C) @(negedge Clock);
                rx_byte[i] = Tx_Serial;
            end
            repeat (C) @(negedge Clock);
            rx_ok = rx_ok && (Tx_Serial === 1'b1);
            if (rx_ok) rx_q.push_back(rx_byte);
            else       rx_bad++;
            rx_frames++;
        end
        rx_prev = Tx_Serial;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, s);
        end
    endtask

    // Line level for a frame popped at cur_t: start for C cycles, 8 data bits LSB first, then high.
    function automatic logic exp_line(input int t);
        int d;
        d = t - cur_t;
        if (d >= 1 && d <= C) return 1'b0;
        if (d > C && d <= 9 * C) return cur_b[3'((d - 1) / C - 1)];
        return 1'b1;
    endfunction

    function automatic logic exp_active(input int t);
        int d;
        d = t - cur_t;
        return (d >= 1 && d <= FRAME);
    endfunction

    function automatic logic exp_done(input int t);
        return (t - cur_t) == FRAME + 1;
    endfunction

    // One clock cycle: apply inputs, check every output against the model, advance the model.
    task automatic tick(input logic dv, input logic [7:0] b, input logic rst);
        logic rdy;
        Tx_DV   = dv;
        Tx_Byte = b;
        reset   = rst;
        chk("count",    32'(Fifo_Count),  32'(mq.size()));
        chk("ready",    32'(Tx_Ready),    32'(mq.size() < D));
        chk("overflow", 32'(Tx_Overflow), 32'(ovf_exp));
        chk("serial",   32'(Tx_Serial),   32'(exp_line(s)));
        chk("active",   32'(Tx_Active),   32'(exp_active(s)));
        chk("done",     32'(Tx_Done),     32'(exp_done(s)));
        if (Tx_Done === 1'b1)     done_cycles.push_back(s);
        if (Tx_Overflow === 1'b1) ovf_cycles.push_back(s);
        if (Tx_Serial === 1'b0)   low_cnt++;
        if (rst) begin
            mq.delete();
            cur_t       = -1000;
            next_pop_ok = s + 1;
            ovf_exp     = 1'b0;
        end else begin
            rdy = (mq.size() < D);
            if (s >= next_pop_ok && mq.size() > 0) begin
                cur_t       = s;
                cur_b       = mq.pop_front();
                exp_rx.push_back(cur_b);
                next_pop_ok = s + FRAME + 2;
            end
            ovf_exp = dv && !rdy;
            if (dv && rdy)  mq.push_back(b);
            else if (dv)    drop_cycles.push_back(s);
        end
        @(posedge Clock);
        #1;
        s++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    // Received bytes must equal the popped bytes in order, with clean framing.
    task automatic rx_compare(input string tag);
        chk({tag, "_nframes"}, 32'(rx_q.size()), 32'(exp_rx.size()));
        chk({tag, "_badframes"}, 32'(rx_bad), 32'd0);
        for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
            chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_rx[i]));
        rx_q.delete();
        exp_rx.delete();
        rx_bad = 0;
    endtask

    initial begin
        repeat (3) @(posedge Clock);
        #1;
        // Reset state while reset is still held.
        tick(1'b0, 8'h00, 1'b1);

        // 1: single 0xA5 pushed at relative cycle 0.
        base = s;
        done_cycles.delete();
        tick(1'b1, 8'hA5, 1'b0);
        idle(95);
        chk("t1_ndone", 32'(done_cycles.size()), 32'd1);
        if (done_cycles.size() > 0) chk("t1_done_cycle", 32'(done_cycles[0] - base), 32'd82);
        chk("t1_rx_n", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("t1_rx_byte", 32'(rx_q[0]), 32'hA5);
        rx_compare("t1");

        // 2: eight consecutive pushes 0x00..0x07; three are dropped.
        base = s;
        ovf_cycles.delete();
        drop_cycles.delete();
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(i), 1'b0);
        idle(430);
        chk("t2_ndrop", 32'(drop_cycles.size()), 32'd3);
        chk("t2_novf",  32'(ovf_cycles.size()),  32'd3);
        for (int i = 0; i < 3 && i < drop_cycles.size() && i < ovf_cycles.size(); i++) begin
            chk("t2_drop_cycle", 32'(drop_cycles[i] - base), 32'(5 + i));
            chk("t2_ovf_cycle",  32'(ovf_cycles[i]),  32'(drop_cycles[i] + 1));
        end
        chk("t2_rx_n", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("t2_rx_order", 32'(rx_q[i]), 32'(i));
        rx_compare("t2");

        // 3: 0x00 then 0xFF back-to-back.
        done_cycles.delete();
        low_cnt = 0;
        tick(1'b1, 8'h00, 1'b0);
        tick(1'b1, 8'hFF, 1'b0);
        idle(190);
        chk("t3_low_cycles", 32'(low_cnt), 32'(10 * C));
        chk("t3_ndone", 32'(done_cycles.size()), 32'd2);
        if (done_cycles.size() == 2) chk("t3_spacing", 32'(done_cycles[1] - done_cycles[0]), 32'(FRAME + 2));
        rx_compare("t3");

        // 4: reset in the middle of data bit 3 with two bytes still queued.
        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b1, 8'hC3, 1'b0);
        tick(1'b1, 8'h55, 1'b0);
        guard = 0;
        while (s < cur_t + 4 * C + C / 2 && guard < 200) begin
            tick(1'b0, 8'h00, 1'b0);
            guard++;
        end
        chk("t4_queued", 32'(Fifo_Count), 32'd2);
        tick(1'b0, 8'h00, 1'b1);
        chk("t4_serial_after_rst", 32'(Tx_Serial), 32'd1);
        chk("t4_active_after_rst", 32'(Tx_Active), 32'd0);
        chk("t4_count_after_rst",  32'(Fifo_Count), 32'd0);
        rxn = rx_frames;
        done_cycles.delete();
        low_cnt = 0;
        idle(30 * C);
        chk("t4_no_low_after_rst", 32'(low_cnt), 32'd0);
        chk("t4_no_done_after_rst", 32'(done_cycles.size()), 32'd0);
        chk("t4_rx_at_most_aborted", 32'((rx_frames - rxn) <= 1), 32'd1);
        rx_q.delete();
        exp_rx.delete();
        rx_bad = 0;

        // 5: push into an empty buffer with the FSM idle.
        tick(1'b1, 8'h5A, 1'b0);
        chk("t5_count_1",  32'(Fifo_Count), 32'd1);
        chk("t5_active_0", 32'(Tx_Active),  32'd0);
        tick(1'b0, 8'h00, 1'b0);
        chk("t5_count_0",  32'(Fifo_Count), 32'd0);
        chk("t5_active_1", 32'(Tx_Active),  32'd1);
        idle(90);
        rx_compare("t5");

        // 6: push while full in the very cycle a pop happens.
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
        guard = 0;
        while (Tx_Done !== 1'b1 && guard < 2 * FRAME) begin
            tick(1'b0, 8'h00, 1'b0);
            guard++;
        end
        chk("t6_saw_done", 32'(guard < 2 * FRAME), 32'd1);
        tick(1'b0, 8'h00, 1'b0);
        chk("t6_full_before", 32'(Fifo_Count), 32'd4);
        chk("t6_not_ready",   32'(Tx_Ready),   32'd0);
        tick(1'b1, 8'h77, 1'b0);
        chk("t6_overflow", 32'(Tx_Overflow), 32'd1);
        chk("t6_count_3",  32'(Fifo_Count),  32'd3);
        idle(4 * (FRAME + 2) + 20);
        chk("t6_rx_n", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("t6_rx_order", 32'(rx_q[i]), 32'(8'h10 + i));
        rx_compare("t6");

        // Random traffic: sparse then dense strobes with random bytes.
        for (int i = 0; i < 2000; i++) begin
            if (i < 1000) tick(($urandom_range(0, 39) == 0), 8'($urandom), 1'b0);
            else          tick(($urandom_range(0, 3) == 0),  8'($urandom), 1'b0);
        end
        idle(5 * (FRAME + 2) + 40);
        rx_compare("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
